// File: rtl/mem_access_unit_if.sv
// Data-bus request/response channel between the MEM-stage access engine and the bus bridge.
// master = access engine (issues requests), slave = bridge / memory model.
interface mem_access_unit_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic [31:0] data_rdata;
  logic        data_data_ok;

  modport master (
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_rdata, data_data_ok
  );

  modport slave (
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_rdata, data_data_ok
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: issues one bus access per instruction, stalls until done.
// Optional macro ADDR_EXC_EN: misaligned accesses raise exc_adel/exc_ades instead of being aligned down.
module mem_access_unit #(
  parameter int unsigned BUS_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  MemReadType,
  input  logic [31:0] addr,
  input  logic [31:0] wdata_in,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        resp_valid,
  output logic        bus_err,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic [31:0] badvaddr,
  mem_access_unit_if.master bus
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP, DONE} state_t;
  state_t stateReg, stateNext;

  logic        memOp, start, addrExc, timeoutHit, reqWr;
  logic [1:0]  reqSize;
  logic [31:0] reqAddr, reqWdata;
  logic [3:0]  reqWstrb;
  logic        wrReg, signReg, errReg;
  logic [1:0]  sizeReg;
  logic [31:0] addrReg, wdataReg, loadDataReg, extData;
  logic [3:0]  wstrbReg;
  logic [15:0] cntReg;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  assign memOp   = valid_in & (MemReadM | MemWriteM);
  assign reqWr   = MemWriteM & ~MemReadM;
  // Size code 11 (including the 111 "none" encoding) is treated as a word access.
  assign reqSize = (MemReadType[1:0] == 2'b11) ? 2'b10 : MemReadType[1:0];

`ifdef ADDR_EXC_EN
  logic misalign, excLoad, excStore;
  assign misalign = (reqSize == 2'b01 && addr[0]) || (reqSize == 2'b10 && addr[1:0] != 2'b00);
  assign excLoad  = ~rst & valid_in & ~flush & MemReadM & misalign;
  assign excStore = ~rst & valid_in & ~flush & reqWr & misalign;
  assign addrExc  = excLoad | excStore;
  assign exc_adel = excLoad;
  assign exc_ades = excStore;
  assign badvaddr = addrExc ? addr : 32'h0;
`else
  assign addrExc  = 1'b0;
  assign exc_adel = 1'b0;
  assign exc_ades = 1'b0;
  assign badvaddr = 32'h0;
`endif

  assign start = memOp & ~flush & ~addrExc & ~rst & (stateReg == IDLE);

  always_comb begin
    reqAddr = addr;
    if (reqSize == 2'b01)      reqAddr[0]   = 1'b0;
    else if (reqSize == 2'b10) reqAddr[1:0] = 2'b00;
  end

  always_comb begin
    case (reqSize)
      2'b00:   reqWdata = {4{wdata_in[7:0]}};
      2'b01:   reqWdata = {2{wdata_in[15:0]}};
      default: reqWdata = wdata_in;
    endcase
  end

  // Lane gi is written when the (aligned) access covers it; loads never assert strobes.
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : gLane
    assign reqWstrb[gi] = reqWr & ((reqSize == 2'b10) ||
                                   (reqSize == 2'b01 && reqAddr[1] == 1'(gi / 2)) ||
                                   (reqSize == 2'b00 && reqAddr[1:0] == 2'(gi)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrReg    <= 1'b0;
      signReg  <= 1'b0;
      sizeReg  <= 2'b00;
      addrReg  <= 32'h0;
      wstrbReg <= 4'h0;
      wdataReg <= 32'h0;
    end else if (start) begin
      wrReg    <= reqWr;
      signReg  <= MemReadType[2];
      sizeReg  <= reqSize;
      addrReg  <= reqAddr;
      wstrbReg <= reqWstrb;
      wdataReg <= reqWdata;
    end
  end

  assign timeoutHit = (BUS_TIMEOUT != 0) && (({1'b0, cntReg} + 17'd1) == 17'(BUS_TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) stateReg <= IDLE;
    else     stateReg <= stateNext;
  end

  // Counts completed WAIT cycles; cleared whenever WAIT is entered or left.
  always_ff @(posedge clk) begin
    if (rst || stateReg != WAIT || stateNext != WAIT) cntReg <= 16'h0;
    else                                              cntReg <= cntReg + 16'd1;
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE: if (start) stateNext = bus.data_addr_ok ? WAIT : REQ;
      REQ: begin
        if (bus.data_addr_ok) stateNext = WAIT;
        else if (flush)       stateNext = IDLE;
      end
      WAIT: begin
        // A response arriving together with flush is simply discarded.
        if (bus.data_data_ok) stateNext = flush ? IDLE : DONE;
        else if (flush)       stateNext = DROP;
        else if (timeoutHit)  stateNext = DONE;
      end
      DROP: if (bus.data_data_ok) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    byteSel = bus.data_rdata[{addrReg[1:0], 3'b000} +: 8];
    halfSel = addrReg[1] ? bus.data_rdata[31:16] : bus.data_rdata[15:0];
    case (sizeReg)
      2'b00:   extData = {{24{signReg & byteSel[7]}}, byteSel};
      2'b01:   extData = {{16{signReg & halfSel[15]}}, halfSel};
      default: extData = bus.data_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      loadDataReg <= 32'h0;
      errReg      <= 1'b0;
    end else begin
      errReg <= 1'b0;
      if (stateReg == WAIT && stateNext == DONE) begin
        if (bus.data_data_ok) begin
          loadDataReg <= wrReg ? 32'h0 : extData;
        end else begin
          loadDataReg <= 32'h0;
          errReg      <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    stall          = start;
    bus.data_req   = 1'b0;
    bus.data_wr    = 1'b0;
    bus.data_size  = 2'b00;
    bus.data_wstrb = 4'h0;
    bus.data_addr  = 32'h0;
    bus.data_wdata = 32'h0;
    case (stateReg)
      IDLE: if (start) begin
        bus.data_req   = 1'b1;
        bus.data_wr    = reqWr;
        bus.data_size  = reqSize;
        bus.data_wstrb = reqWstrb;
        bus.data_addr  = reqAddr;
        bus.data_wdata = reqWdata;
      end
      REQ: begin
        stall          = 1'b1;
        bus.data_req   = 1'b1;
        bus.data_wr    = wrReg;
        bus.data_size  = sizeReg;
        bus.data_wstrb = wstrbReg;
        bus.data_addr  = addrReg;
        bus.data_wdata = wdataReg;
      end
      WAIT, DROP: stall = 1'b1;
      default: ;
    endcase
  end

  assign resp_valid = (stateReg == DONE);
  assign load_data  = loadDataReg;
  assign bus_err    = errReg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table of single accesses plus multi-cycle corner sequences.
// Built with BUS_TIMEOUT=4; the ADDR_EXC_EN sections follow the macro.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst, valid_in, MemReadM, MemWriteM, flush;
  logic [2:0]  MemReadType;
  logic [31:0] addr, wdata_in;
  logic        stall, resp_valid, bus_err, exc_adel, exc_ades;
  logic [31:0] load_data, badvaddr;
  int          nCompared = 0;
  int          nMismatch = 0;

  mem_access_unit_if bus();

  mem_access_unit #(.BUS_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .MemReadType(MemReadType), .addr(addr), .wdata_in(wdata_in), .flush(flush),
    .stall(stall), .load_data(load_data), .resp_valid(resp_valid), .bus_err(bus_err),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .badvaddr(badvaddr), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr;
    logic [2:0]  typ;
    logic [31:0] a, wd, rdata;
    logic [1:0]  eSize;
    logic [3:0]  eStrb;
    logic [31:0] eAddr, eWdata, eLoad;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idleIn();
    valid_in = 0; MemReadM = 0; MemWriteM = 0; MemReadType = 3'b111;
    addr = 0; wdata_in = 0; flush = 0;
    bus.data_addr_ok = 0; bus.data_data_ok = 0; bus.data_rdata = 0;
  endtask

  task automatic addVec(input logic rd, input logic wr, input logic [2:0] typ, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rdata, input logic [1:0] eSize,
                        input logic [3:0] eStrb, input logic [31:0] eAddr, input logic [31:0] eWdata,
                        input logic [31:0] eLoad);
    vec_t v;
    v = '{rd, wr, typ, a, wd, rdata, eSize, eStrb, eAddr, eWdata, eLoad};
    vecs.push_back(v);
  endtask

  task automatic applyOp(input logic rd, input logic wr, input logic [2:0] typ,
                         input logic [31:0] a, input logic [31:0] wd);
    valid_in = 1; MemReadM = rd; MemWriteM = wr; MemReadType = typ; addr = a; wdata_in = wd;
  endtask

  // Fastest access: addr_ok with start in c0, data_ok in c1, DONE in c2.
  task automatic runVec(input int idx);
    vec_t v;
    v = vecs[idx];
    @(negedge clk);
    applyOp(v.rd, v.wr, v.typ, v.a, v.wd);
    bus.data_addr_ok = 1;
    #1;
    chk($sformatf("v%0d req", idx), 32'(bus.data_req), 32'd1);
    chk($sformatf("v%0d stall_c0", idx), 32'(stall), 32'd1);
    chk($sformatf("v%0d wr", idx), 32'(bus.data_wr), 32'(v.wr));
    chk($sformatf("v%0d size", idx), 32'(bus.data_size), 32'(v.eSize));
    chk($sformatf("v%0d wstrb", idx), 32'(bus.data_wstrb), 32'(v.eStrb));
    chk($sformatf("v%0d addr", idx), bus.data_addr, v.eAddr);
    chk($sformatf("v%0d wdata", idx), bus.data_wdata, v.eWdata);
    chk($sformatf("v%0d exc", idx), {30'h0, exc_adel, exc_ades}, 32'h0);
    chk($sformatf("v%0d badvaddr", idx), badvaddr, 32'h0);
    @(negedge clk);
    bus.data_addr_ok = 0; bus.data_data_ok = 1; bus.data_rdata = v.rdata;
    #1;
    chk($sformatf("v%0d stall_c1", idx), 32'(stall), 32'd1);
    chk($sformatf("v%0d req_c1", idx), 32'(bus.data_req), 32'd0);
    @(negedge clk);
    bus.data_data_ok = 0;
    #1;
    chk($sformatf("v%0d resp_valid", idx), 32'(resp_valid), 32'd1);
    chk($sformatf("v%0d stall_c2", idx), 32'(stall), 32'd0);
    chk($sformatf("v%0d load_data", idx), load_data, v.eLoad);
    chk($sformatf("v%0d bus_err", idx), 32'(bus_err), 32'd0);
    chk($sformatf("v%0d no_start_in_done", idx), 32'(bus.data_req), 32'd0);
    @(negedge clk);
    idleIn();
    #1;
    chk($sformatf("v%0d resp_after", idx), 32'(resp_valid), 32'd0);
    $display("vec %0d rd=%0b wr=%0b type=%03b addr=%h load_data=%h", idx, v.rd, v.wr, v.typ, v.a, load_data);
  endtask

  initial begin
    // rd wr typ     addr          wdata         rdata         size  strb     bus addr      bus wdata     load
    addVec(1, 0, 3'b100, 32'h80001003, 32'h0,        32'h80123456, 2'b00, 4'b0000, 32'h80001003, 32'h0,        32'hFFFFFF80);
    addVec(1, 0, 3'b001, 32'h80002000, 32'h0,        32'h1234F00D, 2'b01, 4'b0000, 32'h80002000, 32'h0,        32'h0000F00D);
    addVec(1, 0, 3'b101, 32'h80002000, 32'h0,        32'h1234F00D, 2'b01, 4'b0000, 32'h80002000, 32'h0,        32'hFFFFF00D);
    addVec(1, 0, 3'b000, 32'h80000001, 32'h0,        32'h1234F00D, 2'b00, 4'b0000, 32'h80000001, 32'h0,        32'h000000F0);
    addVec(1, 0, 3'b010, 32'h80000010, 32'h0,        32'hDEADBEEF, 2'b10, 4'b0000, 32'h80000010, 32'h0,        32'hDEADBEEF);
    addVec(0, 1, 3'b000, 32'h80000002, 32'h000000A5, 32'h55555555, 2'b00, 4'b0100, 32'h80000002, 32'hA5A5A5A5, 32'h0);
    addVec(0, 1, 3'b010, 32'h80000004, 32'h11223344, 32'h55555555, 2'b10, 4'b1111, 32'h80000004, 32'h11223344, 32'h0);
    addVec(0, 1, 3'b001, 32'h80000000, 32'h0000BEEF, 32'h55555555, 2'b01, 4'b0011, 32'h80000000, 32'hBEEFBEEF, 32'h0);
    addVec(1, 0, 3'b111, 32'h80000008, 32'h0,        32'hCAFEF00D, 2'b10, 4'b0000, 32'h80000008, 32'h0,        32'hCAFEF00D);
    addVec(1, 0, 3'b100, 32'h80000000, 32'h0,        32'h1234567F, 2'b00, 4'b0000, 32'h80000000, 32'h0,        32'h0000007F);
`ifndef ADDR_EXC_EN
    addVec(1, 0, 3'b010, 32'h80000002, 32'h0,        32'h13579BDF, 2'b10, 4'b0000, 32'h80000000, 32'h0,        32'h13579BDF);
    addVec(1, 0, 3'b101, 32'h80000003, 32'h0,        32'h80017FFF, 2'b01, 4'b0000, 32'h80000002, 32'h0,        32'hFFFF8001);
`endif

    idleIn();
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset req", 32'(bus.data_req), 32'd0);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset load_data", load_data, 32'h0);
    chk("reset bus_err", 32'(bus_err), 32'd0);
    chk("reset exc", {30'h0, exc_adel, exc_ades}, 32'h0);
    $display("reset released");

    for (int i = 0; i < vecs.size(); i++) runVec(i);

    // SH with addr_ok held off three cycles; inputs scrambled to prove fields are latched.
    @(negedge clk);
    applyOp(0, 1, 3'b001, 32'h80001002, 32'h1234ABCD);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin
        @(negedge clk);
        addr = 32'hDEAD0000; wdata_in = 32'h0;
      end
      bus.data_addr_ok = (c == 3);
      #1;
      chk($sformatf("sh req c%0d", c), 32'(bus.data_req), 32'd1);
      chk($sformatf("sh stall c%0d", c), 32'(stall), 32'd1);
      chk($sformatf("sh addr c%0d", c), bus.data_addr, 32'h80001002);
      chk($sformatf("sh wstrb c%0d", c), 32'(bus.data_wstrb), 32'b1100);
      chk($sformatf("sh wdata c%0d", c), bus.data_wdata, 32'hABCDABCD);
      chk($sformatf("sh size c%0d", c), {31'h0, bus.data_wr} | (32'(bus.data_size) << 1), 32'h3);
    end
    @(negedge clk);
    bus.data_addr_ok = 0; bus.data_data_ok = 1;
    #1;
    chk("sh wait stall", 32'(stall), 32'd1);
    chk("sh wait req", 32'(bus.data_req), 32'd0);
    @(negedge clk);
    bus.data_data_ok = 0;
    #1;
    chk("sh done resp", 32'(resp_valid), 32'd1);
    chk("sh done stall", 32'(stall), 32'd0);
    @(negedge clk);
    idleIn();
    $display("store-half delayed-accept transaction complete");

    // Flush in WAIT: response two cycles later must be dropped.
    @(negedge clk);
    applyOp(1, 0, 3'b010, 32'h80000020, 32'h0);
    bus.data_addr_ok = 1;
    @(negedge clk);
    idleIn();
    flush = 1;
    #1;
    chk("drop wait stall", 32'(stall), 32'd1);
    @(negedge clk);
    flush = 0;
    #1;
    chk("drop stall", 32'(stall), 32'd1);
    chk("drop resp c2", 32'(resp_valid), 32'd0);
    @(negedge clk);
    bus.data_data_ok = 1; bus.data_rdata = 32'hFFFFFFFF;
    #1;
    chk("drop stall data_ok", 32'(stall), 32'd1);
    chk("drop resp c3", 32'(resp_valid), 32'd0);
    @(negedge clk);
    bus.data_data_ok = 0;
    #1;
    chk("drop resp c4", 32'(resp_valid), 32'd0);
    chk("drop stall c4", 32'(stall), 32'd0);
    $display("flushed load dropped");
    runVec(0);

    // Flush in REQ withdraws the request; a stray data_ok afterwards is ignored.
    @(negedge clk);
    applyOp(1, 0, 3'b010, 32'h80000030, 32'h0);
    #1;
    chk("reqflush req c0", 32'(bus.data_req), 32'd1);
    @(negedge clk);
    idleIn();
    flush = 1;
    #1;
    chk("reqflush req c1", 32'(bus.data_req), 32'd1);
    @(negedge clk);
    flush = 0;
    #1;
    chk("reqflush req c2", 32'(bus.data_req), 32'd0);
    chk("reqflush stall c2", 32'(stall), 32'd0);
    bus.data_data_ok = 1;
    @(negedge clk);
    bus.data_data_ok = 0;
    #1;
    chk("reqflush stray resp", 32'(resp_valid), 32'd0);
    chk("reqflush stray stall", 32'(stall), 32'd0);
    $display("request withdrawn by flush");

    // Watchdog: accept in c0, no response, DONE with bus_err in c5.
    @(negedge clk);
    applyOp(1, 0, 3'b010, 32'h80000040, 32'h0);
    bus.data_addr_ok = 1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      bus.data_addr_ok = 0;
      #1;
      chk($sformatf("wd stall c%0d", c), 32'(stall), 32'd1);
      chk($sformatf("wd resp c%0d", c), {30'h0, resp_valid, bus_err}, 32'h0);
    end
    @(negedge clk);
    #1;
    chk("wd c5 resp/err", {30'h0, resp_valid, bus_err}, 32'h3);
    chk("wd c5 load_data", load_data, 32'h0);
    chk("wd c5 stall", 32'(stall), 32'd0);
    @(negedge clk);
    idleIn();
    #1;
    chk("wd c6 resp/err", {30'h0, resp_valid, bus_err}, 32'h0);
    $display("watchdog abort transaction");

    // Reset during WAIT clears everything, including a nonzero load_data.
    runVec(4);
    @(negedge clk);
    applyOp(1, 0, 3'b010, 32'h80000050, 32'h0);
    bus.data_addr_ok = 1;
    @(negedge clk);
    bus.data_addr_ok = 0;
    rst = 1;
    #1;
    chk("rst wait stall", 32'(stall), 32'd1);
    @(negedge clk);
    rst = 0;
    idleIn();
    bus.data_data_ok = 1;
    #1;
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst req", 32'(bus.data_req), 32'd0);
    chk("rst resp/err", {30'h0, resp_valid, bus_err}, 32'h0);
    chk("rst load_data", load_data, 32'h0);
    @(negedge clk);
    bus.data_data_ok = 0;
    #1;
    chk("rst stray resp", 32'(resp_valid), 32'd0);
    $display("reset during wait");

`ifdef ADDR_EXC_EN
    @(negedge clk);
    applyOp(1, 0, 3'b010, 32'h80000002, 32'h0);
    #1;
    chk("adel flag", {30'h0, exc_adel, exc_ades}, 32'h2);
    chk("adel badvaddr", badvaddr, 32'h80000002);
    chk("adel req", 32'(bus.data_req), 32'd0);
    chk("adel stall", 32'(stall), 32'd0);
    @(negedge clk);
    applyOp(0, 1, 3'b001, 32'h80000101, 32'h0);
    #1;
    chk("ades flag", {30'h0, exc_adel, exc_ades}, 32'h1);
    chk("ades badvaddr", badvaddr, 32'h80000101);
    chk("ades req", 32'(bus.data_req), 32'd0);
    flush = 1;
    #1;
    chk("ades flushed", {30'h0, exc_adel, exc_ades}, 32'h0);
    @(negedge clk);
    idleIn();
    #1;
    chk("exc no residue", 32'(stall), 32'd0);
    $display("address exception checks");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end
endmodule
